e15_proc_param: RTL

Parametrised successor to the 4-bit E15 processor core. Register count, data width and program depth are configurable. The program memory is writable from a load port, so programs are no longer compiled in. Execution is a two-state fetch/execute multicycle FSM with explicit start, halt instruction, retire strobe and retired-instruction counter. It sits standalone under the testbench clock, with the bench loading the program, starting the core and checking architectural state via the debug port.

---
 rtl/e15_proc_param.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/e15_proc_param.sv
// E15 processor core: parametrised registers/width/program depth, loadable program memory,
// fetch/execute multicycle FSM. Optional carry flag and jc/jnc enabled by E15_CARRY_FLAG_EN.
module e15_proc_param #(
    parameter  int DATA_W  = 4,
    parameter  int NREG    = 4,
    parameter  int PC_W    = 4,
    parameter  int CNT_W   = 16,
    localparam int REG_AW  = $clog2(NREG),
    localparam int INSTR_W = 4 + 2 * REG_AW + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [PC_W-1:0]    pc_o,
    output logic               z_o,
    output logic               c_o,
    output logic               halted,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_cnt
);

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    localparam logic [3:0] OP_JMP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [3:0] OP_JZ   = 4'b0010;
    localparam logic [3:0] OP_JNZ  = 4'b0011;
    localparam logic [3:0] OP_JC   = 4'b0100;
    localparam logic [3:0] OP_JNC  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b1000;
    localparam logic [3:0] OP_MOVI = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_ADDI = 4'b1011;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_SUBI = 4'b1101;
    localparam logic [3:0] OP_CMP  = 4'b1110;
    localparam logic [3:0] OP_CMPI = 4'b1111;

    // With the carry flag the adder carries one extra bit holding carry-out / borrow.
`ifdef E15_CARRY_FLAG_EN
    localparam int ARITH_W = DATA_W + 1;
`else
    localparam int ARITH_W = DATA_W;
`endif

    logic [1:0]         r_state;
    logic [INSTR_W-1:0] r_mem [2**PC_W];
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_pc;
    logic [DATA_W-1:0]  r_regs [NREG];
    logic               r_z;
    logic               r_retire;
    logic [CNT_W-1:0]   r_cnt;
`ifdef E15_CARRY_FLAG_EN
    logic               r_c;
    logic               w_carry;
`endif

    logic [3:0]         w_op;
    logic [REG_AW-1:0]  w_src;
    logic [REG_AW-1:0]  w_dst;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W-1:0]  w_src_val;
    logic [DATA_W-1:0]  w_dst_val;
    logic [DATA_W-1:0]  w_opb;
    logic [ARITH_W-1:0] w_sum;
    logic [ARITH_W-1:0] w_diff;
    logic [DATA_W-1:0]  w_res;
    logic               w_wr_en;
    logic               w_flag_en;
    logic               w_take;
    logic               w_halt_op;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_pc_jmp;

    assign w_op      = r_ir[INSTR_W-1 -: 4];
    assign w_src     = r_ir[DATA_W + REG_AW +: REG_AW];
    assign w_dst     = r_ir[DATA_W +: REG_AW];
    assign w_imm     = r_ir[DATA_W-1:0];
    assign w_src_val = r_regs[w_src];
    assign w_dst_val = r_regs[w_dst];

    // Bit 0 of an ALU opcode selects the immediate form.
    assign w_opb  = w_op[0] ? w_imm : w_src_val;
    assign w_sum  = ARITH_W'(w_dst_val) + ARITH_W'(w_opb);
    assign w_diff = ARITH_W'(w_dst_val) - ARITH_W'(w_opb);

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_jmp = r_pc + PC_W'(w_imm);

    always_comb begin
        w_res     = w_sum[DATA_W-1:0];
        w_wr_en   = 1'b0;
        w_flag_en = 1'b0;
        w_take    = 1'b0;
        w_halt_op = 1'b0;
`ifdef E15_CARRY_FLAG_EN
        w_carry   = 1'b0;
`endif
        case (w_op)
            OP_JMP:  w_take = 1'b1;
            OP_HALT: w_halt_op = 1'b1;
            OP_JZ:   w_take = r_z;
            OP_JNZ:  w_take = ~r_z;
`ifdef E15_CARRY_FLAG_EN
            OP_JC:   w_take = r_c;
            OP_JNC:  w_take = ~r_c;
`endif
            OP_MOV: begin
                w_res   = w_src_val;
                w_wr_en = 1'b1;
            end
            OP_MOVI: begin
                w_res   = w_imm;
                w_wr_en = 1'b1;
            end
            OP_ADD, OP_ADDI: begin
                w_res     = w_sum[DATA_W-1:0];
                w_wr_en   = 1'b1;
                w_flag_en = 1'b1;
`ifdef E15_CARRY_FLAG_EN
                w_carry   = w_sum[DATA_W];
`endif
            end
            OP_SUB, OP_SUBI, OP_CMP, OP_CMPI: begin
                w_res     = w_diff[DATA_W-1:0];
                w_wr_en   = ~w_op[1];
                w_flag_en = 1'b1;
`ifdef E15_CARRY_FLAG_EN
                w_carry   = ~w_diff[DATA_W];
`endif
            end
            default: ;
        endcase
    end

    // Program memory has no reset; loads are accepted only while the core is halted.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == ST_HALT)) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_HALT;
            r_ir     <= '0;
            r_pc     <= '0;
            r_z      <= 1'b0;
            r_retire <= 1'b0;
            r_cnt    <= '0;
`ifdef E15_CARRY_FLAG_EN
            r_c      <= 1'b0;
`endif
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_HALT: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= r_mem[r_pc];
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_retire <= 1'b1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    r_pc     <= w_take ? w_pc_jmp : w_pc_inc;
                    if (w_wr_en) begin
                        r_regs[w_dst] <= w_res;
                    end
                    if (w_flag_en) begin
                        r_z <= (w_res == '0);
`ifdef E15_CARRY_FLAG_EN
                        r_c <= w_carry;
`endif
                    end
                    r_state <= w_halt_op ? ST_HALT : ST_FETCH;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign dbg_data    = r_regs[dbg_sel];
    assign pc_o        = r_pc;
    assign z_o         = r_z;
    assign halted      = (r_state == ST_HALT);
    assign retire      = r_retire;
    assign retired_cnt = r_cnt;
`ifdef E15_CARRY_FLAG_EN
    assign c_o         = r_c;
`else
    assign c_o         = 1'b0;
`endif

endmodule
